// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter and sequencer for the shared 8-bit
// memory/peripheral bus (RAM, UART).
// Two masters request transfers. The winner's fields are latched at grant.
// The bus is driven for 1 + WAIT_STATES ACCESS cycles, then a one-cycle ack is
// returned in ACK. The bus is idle (IDLE_SEL selected, oe/we low) outside ACCESS.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mX_req/sel/addr/we/wdata master X request and transfer fields
//   mX_ack, mX_rdata         master X completion pulse and read data
//   bus_device_select/addr/we/oe/wdata  shared bus outputs
//   bus_rdata                shared device read data
//   busy, owner              transfer in progress, and its latched grant index
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [2:0]  IDLE_SEL    = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [2:0]  m0_sel,
  input  logic [15:0] m0_addr,
  input  logic        m0_we,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic [2:0]  m1_sel,
  input  logic [15:0] m1_addr,
  input  logic        m1_we,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [2:0]  bus_device_select,
  output logic [15:0] bus_addr,
  output logic        bus_we,
  output logic        bus_oe,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state;
  logic        rr_last;
  logic [3:0]  wait_cnt;
  logic [15:0] addr_l;
  logic        we_l;
  logic [7:0]  wdata_l;

  logic        grant_valid;
  logic        grant_idx;
  logic [2:0]  g_sel;
  logic [15:0] g_addr;
  logic        g_we;
  logic [7:0]  g_wdata;

  // On a tie the master that was not granted last wins; a lone request always wins.
  always_comb begin
    grant_valid = m0_req | m1_req;
    grant_idx   = m1_req & (~m0_req | ~rr_last);
    g_sel       = grant_idx ? m1_sel   : m0_sel;
    g_addr      = grant_idx ? m1_addr  : m0_addr;
    g_we        = grant_idx ? m1_we    : m0_we;
    g_wdata     = grant_idx ? m1_wdata : m0_wdata;
  end

  // Address and write data follow the latched fields. Devices ignore them
  // unless selected, and select/oe/we are only active in ACCESS.
  assign bus_addr  = addr_l;
  assign bus_wdata = wdata_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      owner             <= 1'b0;
      rr_last           <= 1'b1;
      wait_cnt          <= '0;
      addr_l            <= '0;
      we_l              <= 1'b0;
      wdata_l           <= '0;
      m0_rdata          <= '0;
      m1_rdata          <= '0;
      m0_ack            <= 1'b0;
      m1_ack            <= 1'b0;
      busy              <= 1'b0;
      bus_device_select <= IDLE_SEL;
      bus_oe            <= 1'b0;
      bus_we            <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner             <= grant_idx;
            rr_last           <= grant_idx;
            addr_l            <= g_addr;
            we_l              <= g_we;
            wdata_l           <= g_wdata;
            wait_cnt          <= WAIT_INIT;
            busy              <= 1'b1;
            bus_device_select <= g_sel;
            bus_oe            <= ~g_we;
            bus_we            <= g_we;
            state             <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // Final ACCESS edge: the device commits a write, or read data is
            // captured into the owner's rdata register.
            state             <= ACK;
            bus_device_select <= IDLE_SEL;
            bus_oe            <= 1'b0;
            bus_we            <= 1'b0;
            if (owner) begin
              m1_ack <= 1'b1;
              if (!we_l) m1_rdata <= bus_rdata;
            end else begin
              m0_ack <= 1'b1;
              if (!we_l) m0_rdata <= bus_rdata;
            end
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 8-bit memory/peripheral bus (device_select, addr, we, oe, data in/out) used by the RAM and UART blocks.
- Requesters: master 0 (CPU core) and master 1 (DMA/boot loader).
- Arbitrates round-robin, latches the winning request, and drives the bus for a fixed access window. Returns read data and a one-cycle ack.
- Keeps the bus idle (no device selected, oe/we low) between transfers so tri-state data_out is released.

Parameters:
- WAIT_STATES, 0, extra ACCESS cycles per transfer, for slow devices (range 0..15).
- IDLE_SEL, 3'b000, device_select value driven when no transfer is active; must match no device address.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- m0_req  input  1  master 0 request; held high with fields stable until m0_ack
- m0_sel  input  3  master 0 target device_select
- m0_addr  input  16  master 0 address
- m0_we  input  1  master 0: 1 = write, 0 = read
- m0_wdata  input  8  master 0 write data
- m0_ack  output  1  one-cycle completion pulse to master 0
- m0_rdata  output  8  read data for master 0; valid while m0_ack is high
- m1_req, m1_sel, m1_addr, m1_we, m1_wdata, m1_ack, m1_rdata  same widths and meaning for master 1
- bus_device_select  output  3  to all bus devices
- bus_addr  output  16  to bus devices
- bus_we  output  1  write strobe; device commits on clk edge
- bus_oe  output  1  read enable
- bus_wdata  output  8  write data
- bus_rdata  input  8  shared device data_out; Z when no device drives it
- busy  output  1  high in ACCESS or ACK
- owner  output  1  latched grant index (0/1); meaningful only while busy

Behaviour:
- States: IDLE, ACCESS, ACK. Registers: state, owner, rr_last (last granted master), wait counter (4 bits), and latched sel/addr/we/wdata/rdata.
- Reset values: state = IDLE, owner = 0, rr_last = 1 (so master 0 wins the first tie), counter = 0, latched fields = 0, rdata = 8'h00. All outputs inactive: acks 0, busy 0, bus_we 0, bus_oe 0, bus_device_select = IDLE_SEL, bus_addr 0, bus_wdata 0.
- IDLE:
  - One request: grant it.
  - Both requesting: grant the master that is not rr_last.
  - On grant: latch that master's sel/addr/we/wdata, set owner and rr_last, load counter = WAIT_STATES, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - Bus outputs are driven from the latched fields. bus_oe = ~we_l and bus_we = we_l; both are 0 outside ACCESS.
  - If counter != 0: decrement and stay.
  - If counter == 0: go to ACK. On this edge, the device commits a write, or the arbiter captures bus_rdata into rdata for a read.
  - ACCESS lasts exactly 1 + WAIT_STATES cycles.
- ACK:
  - Bus idle. mX_ack = 1 for owner only; mX_rdata = captured rdata.
  - Non-owner rdata holds its previous value. After a write, rdata is unchanged.
  - Next state is always IDLE.
- Latency: request seen in IDLE at cycle N → ACCESS cycles N+1 .. N+1+WAIT_STATES → ack at cycle N+2+WAIT_STATES. Minimum transfer period is 3 + WAIT_STATES cycles.
- Requester rule: a master drops req in its ack cycle or the cycle after. Any req high in IDLE is a new request.
- The losing master's req and fields are ignored until it is granted. Nothing of the loser is latched.
- Fairness: if both masters request continuously, grants alternate 0,1,0,1…
- Changes to mX fields during ACCESS do not affect the bus, because fields are latched at grant.
- Reset mid-operation: the next edge forces IDLE with no ack. A write whose final ACCESS edge coincides with the rst edge may commit; no other side effects.
- bus_rdata is sampled only at the final ACCESS edge. Z/X at other times is ignored.

Test Plan:
- Single read, WAIT_STATES=0: RAM addr 8'h80 = "H" (8'h48); m0 reads sel 3'b001 addr 16'h0080 → bus_oe high for exactly 1 cycle, m0_ack 2 cycles after request, m0_rdata = 8'h48.
- Single write then read: m1 writes 8'hA5 to sel 001 addr 16'h0010 → bus_we high for 1 cycle, m1_ack, m1_rdata unchanged. m1 then reads the same address → 8'hA5.
- Contention: m0 and m1 both request from reset → m0 granted first, m1 next. Both held continuously → 4 transfers go to owners 0,1,0,1, with bus idle (bus_device_select = IDLE_SEL) in every ACK and IDLE cycle.
- WAIT_STATES=3: m0 read → ACCESS lasts 4 cycles, ack at N+5, data captured from the last ACCESS cycle. Change bus_rdata after cycle N+1 and confirm the late value is returned.
- Field stability: m0 changes m0_addr from 16'h0080 to 16'h0081 during ACCESS → bus_addr stays 16'h0080.
- Reset in ACCESS (WAIT_STATES=3), rst asserted in second ACCESS cycle → state IDLE, no ack, bus idle next cycle, rr_last = 1. Idle cycles before the next request: none required.
